// File: rtl/led_pattern_gen_pkg.sv
// Shared mode encodings and FSM state type for the LED pattern generator.
package led_pat_pkg;

  localparam logic [1:0] MODE_BLINK  = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between game logic (master) and the LED pattern generator (slave).
interface led_pattern_gen_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [CNT_W-1:0] burst;
  logic [WIDTH-1:0] l;
  logic             busy;
  logic             done;

  modport master (output en, mode, burst, input l, busy, done);
  modport slave  (input en, mode, burst, output l, busy, done);
endinterface

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: one-cycle tick every TICK_DIV clocks while clr is low.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = !clr && (cnt_reg == LAST);
endmodule

// File: rtl/led_pattern_gen.sv
// Animated LED pattern generator (blink/chase/bounce/fill) with optional finite bursts.
// Define LED_PAT_BOUNCE_EN to build the true bounce mode; otherwise mode 2 behaves as chase.
module led_pattern_gen
  import led_pat_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  led_pattern_gen_if.slave   bus
);
  state_t           state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] burst_reg, burst_next;
  logic [CNT_W-1:0] step_reg, step_next;
  logic [WIDTH-1:0] l_reg, l_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] pat_adv, chase_rot, init_pat;
  logic             tick;
`ifdef LED_PAT_BOUNCE_EN
  logic             dir_reg, dir_next, dir_adv;  // 0 = toward MSB
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_reg != RUN),
    .tick (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign chase_rot[gi] = l_reg[(gi + WIDTH - 1) % WIDTH];
    end
  endgenerate

  assign init_pat = (bus.mode == MODE_BLINK) ? {WIDTH{1'b1}} : WIDTH'(1);

  // Next pattern for the latched mode; mode 2 falls through to chase when bounce is not built.
  always_comb begin
    pat_adv = chase_rot;
`ifdef LED_PAT_BOUNCE_EN
    dir_adv = dir_reg;
`endif
    case (mode_reg)
      MODE_BLINK: pat_adv = ~l_reg;
      MODE_FILL:  pat_adv = (&l_reg) ? '0 : {l_reg[WIDTH-2:0], 1'b1};
`ifdef LED_PAT_BOUNCE_EN
      MODE_BOUNCE: begin
        if (!dir_reg) begin
          pat_adv = l_reg << 1;
          if (pat_adv[WIDTH-1]) dir_adv = 1'b1;
        end else begin
          pat_adv = l_reg >> 1;
          if (pat_adv[0]) dir_adv = 1'b0;
        end
      end
`endif
      default: pat_adv = chase_rot;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    burst_next = burst_reg;
    step_next  = step_reg;
    l_next     = l_reg;
    done_next  = 1'b0;
`ifdef LED_PAT_BOUNCE_EN
    dir_next   = dir_reg;
`endif
    case (state_reg)
      IDLE: begin
        l_next = '0;
        if (bus.en) begin
          mode_next  = bus.mode;
          burst_next = bus.burst;
          l_next     = init_pat;
          step_next  = CNT_W'(1);
          state_next = RUN;
`ifdef LED_PAT_BOUNCE_EN
          dir_next   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!bus.en) begin
          l_next     = '0;
          state_next = IDLE;
        end else if (tick) begin
          if (burst_reg != '0 && step_reg == burst_reg) begin
            l_next     = '0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            l_next    = pat_adv;
            // Saturation only matters for endless runs, where the count is unused.
            step_next = (&step_reg) ? step_reg : step_reg + 1'b1;
`ifdef LED_PAT_BOUNCE_EN
            dir_next  = dir_adv;
`endif
          end
        end
      end
      DONE: begin
        l_next = '0;
        if (!bus.en) state_next = IDLE;
      end
      default: begin
        l_next     = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_BLINK;
      burst_reg <= '0;
      step_reg  <= '0;
      l_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      burst_reg <= burst_next;
      step_reg  <= step_next;
      l_reg     <= l_next;
      done_reg  <= done_next;
    end
  end

`ifdef LED_PAT_BOUNCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_reg <= 1'b0;
    else        dir_reg <= dir_next;
  end
`endif

  assign bus.l    = l_reg;
  assign bus.busy = (state_reg == RUN);
  assign bus.done = done_reg;
endmodule
